ir_cmd_dispatch: RTL
====================

// Module: ir_cmd_dispatch
// PURPOSE
// - Controller between the NEC IR receiver (irq pulse + 8-bit command) and the command consumer.
// - Queues decoded commands in a small FIFO and presents them one at a time on a valid/ready interface.
// - Flags queue overflow and can optionally suppress auto-repeated commands from a held key.
// PARAMETERS
// - DEPTH        4          FIFO entries; power of two, >= 2
// - HOLDOFF_CYC  5_000_000  repeat-suppression window in clk_i cycles (100 ms at 50 MHz)
// - CNT_W        $clog2(DEPTH+1)  occupancy width (derived, not overridden)
// PORTS
// - clk_i        in   1      system clock, 50 MHz
// - rst_n_i      in   1      reset, asynchronous, active-low
// - irq_i        in   1      one-cycle pulse: command_i is valid this cycle
// - command_i    in   8      decoded IR command byte
// - cmd_valid_o  out  1      cmd_o holds a command for the consumer
// - cmd_o        out  8      presented command, stable while cmd_valid_o && !cmd_ready_i
// - cmd_ready_i  in   1      consumer accepts cmd_o this cycle
// - count_o      out  CNT_W  FIFO occupancy (excludes the presented entry)
// - overflow_o   out  1      sticky: a command was dropped because the FIFO was full
// - clr_ovf_i    in   1      clears overflow_o
// BEHAVIOUR
// - Reset: cmd_valid_o=0, cmd_o=0, count_o=0, overflow_o=0, pointers=0, FSM=IDLE, holdoff timer=0.
// - Push: on irq_i, if count_o<DEPTH, command_i written at wr_ptr and wr_ptr incremented.
// - Full-check uses the pre-pop occupancy. A push while full is dropped, even if a pop occurs the same cycle.
// - A dropped push sets overflow_o at the next edge.
// - Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no special case.
// - Occupancy update: push only +1; pop only -1; push+pop same cycle unchanged.
// - Output FSM, registered, two states:
//   - IDLE: cmd_valid_o=0. If FIFO non-empty: load head into cmd_o, pop, go to PRESENT.
//   - PRESENT: cmd_valid_o=1. On cmd_ready_i:
//     - FIFO non-empty: load next head and pop, stay in PRESENT (back-to-back, one command per cycle).
//     - FIFO empty: go to IDLE.
//   - PRESENT without cmd_ready_i: hold cmd_o, no pop.
// - Latency: irq_i in cycle N with empty FIFO and IDLE -> cmd_valid_o=1 in cycle N+2.
//   - Cycle N: write.
//   - Cycle N+1: load + pop.
// - A push and a FSM pop of the same (previously empty) FIFO cannot collide; pop only reads existing entries.
// - overflow_o: set has priority over clr_ovf_i when both occur in the same cycle.
// - Reset mid-operation: FIFO contents and the presented command are discarded immediately.
//   - No command is presented after reset release until a new irq_i.
// CONFIGURATION
// - Macro IR_REPEAT_SUPPRESS_EN.
// - Defined:
//   - Keep last_cmd (8 b) plus a holdoff down-counter of $clog2(HOLDOFF_CYC+1) bits.
//   - irq_i with command_i==last_cmd and timer!=0 is discarded: no push, no overflow.
//     The timer reloads to HOLDOFF_CYC, so a held key stays suppressed.
//   - Any other irq_i is processed as a push attempt. last_cmd=command_i and the timer reloads, even if the push is dropped as full.
//   - Timer decrements each cycle while non-zero. Reset: last_cmd=0, timer=0, so the first command is never suppressed.
// - Undefined: every irq_i is a push attempt; last_cmd and timer are not instantiated.
// TESTING
// - Single: irq_i with 0x45, ready=1 -> cmd_valid_o=1 with cmd_o=0x45 exactly 2 cycles later, for 1 cycle; count_o back to 0.
// - Backpressure: ready=0, push 0x10,0x11,0x12 -> cmd_o=0x10 held; count_o=2; raise ready -> 0x11,0x12 on consecutive cycles.
// - Overflow: ready=0, push DEPTH+2 commands -> count_o=DEPTH, overflow_o=1; extras lost.
//   - Pulse clr_ovf_i -> overflow_o=0.
//   - clr_ovf_i on the same cycle as a dropped push -> overflow_o stays 1.
// - Wrap: 3*DEPTH pushes of 0x00..,ready=1 -> commands delivered in order, none lost, count_o never exceeds DEPTH.
// - Repeat (macro on, HOLDOFF_CYC=100): 0x18 at t=0 and t=50 -> one delivery; 0x18 at t=200 -> second delivery.
//   - 0x18 then 0x19 at t=10 -> both delivered.
//   - Macro off: all delivered.
// - Reset: assert rst_n_i low with 2 queued + 1 presented -> all outputs 0 asynchronously; no delivery after release.

Source files
------------

// File: rtl/ir_cmd_dispatch.sv
// ir_cmd_dispatch: queues NEC IR commands and presents them on valid/ready.
// Optional held-key repeat suppression: define IR_REPEAT_SUPPRESS_EN.
module ir_cmd_dispatch #(
   parameter  int DEPTH       = 4,
   parameter  int HOLDOFF_CYC = 5_000_000,
   localparam int CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             irq_i,
   input  logic [7:0]       command_i,
   output logic             cmd_valid_o,
   output logic [7:0]       cmd_o,
   input  logic             cmd_ready_i,
   output logic [CNT_W-1:0] count_o,
   output logic             overflow_o,
   input  logic             clr_ovf_i
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic {
      IDLE,
      PRESENT
   } state_e;

   logic [7:0]       mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   state_e           state_q;
   state_e           state_d;
   logic [7:0]       cmd_q;
   logic [7:0]       cmd_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             accept;
   logic             push;
   logic             drop;
   logic             pop;

`ifdef IR_REPEAT_SUPPRESS_EN
   localparam int TW = $clog2(HOLDOFF_CYC + 1);

   logic [7:0]    last_q;
   logic [TW-1:0] timer_q;
   logic          suppress;

   assign suppress = irq_i && (command_i == last_q) && (timer_q != '0);
   assign accept   = irq_i && !suppress;

   // Remember the last key and restart the holdoff window on every irq.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_q  <= '0;
         timer_q <= '0;
      end else if (irq_i) begin
         last_q  <= command_i;
         timer_q <= TW'(HOLDOFF_CYC);
      end else if (timer_q != '0) begin
         timer_q <= timer_q - 1'b1;
      end
   end
`else
   assign accept = irq_i;
`endif

   // Full check uses pre-pop occupancy, so a pop never frees room this cycle.
   assign push = accept && (count_q != FULL);
   assign drop = accept && (count_q == FULL);

   // Occupancy bookkeeping.
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointers; power-of-two depth lets pointers wrap naturally.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= command_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   // Output FSM next state: load head and pop whenever the slot is free.
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               cmd_d   = mem_q[rd_ptr_q];
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (cmd_ready_i) begin
               if (count_q != '0) begin
                  pop   = 1'b1;
                  cmd_d = mem_q[rd_ptr_q];
               end else begin
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   // Output FSM registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
      end
   end

   // Sticky overflow; a new drop wins over a simultaneous clear.
   assign ovf_d = drop ? 1'b1 : (clr_ovf_i ? 1'b0 : ovf_q);

   // Overflow flag register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) ovf_q <= 1'b0;
      else          ovf_q <= ovf_d;
   end

   assign cmd_valid_o = (state_q == PRESENT);
   assign cmd_o       = cmd_q;
   assign count_o     = count_q;
   assign overflow_o  = ovf_q;

endmodule
